// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port memory.
// Load/store normally wins; a streak counter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [15:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_valid,
  output logic [15:0] ls_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_next;
  logic [3:0] streak;
  logic       owner;
  logic       cancel;
  logic       can_arb;
  logic       if_wins;
  logic       grant;

  // Fetch only overrides a competing load/store once the streak is exhausted.
  always_comb begin
    can_arb = !reset && ((state == IDLE) || (state == RESP));
    if_wins = if_req && (!ls_req || (streak == LIMIT));
    if_gnt  = can_arb && if_wins;
    ls_gnt  = can_arb && ls_req && !if_wins;
    grant   = if_gnt || ls_gnt;
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = grant ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = grant ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      streak    <= 4'd0;
      owner     <= 1'b0;
      cancel    <= 1'b0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      if_rdata  <= 16'h0000;
      ls_rdata  <= 16'h0000;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      mem_we    <= 1'b0;
    end else begin
      state <= state_next;

      if (!if_req || if_gnt) begin
        streak <= 4'd0;
      end else if (ls_gnt && (streak != LIMIT)) begin
        streak <= streak + 4'd1;
      end

      // mem_we doubles as the latched store flag for the ACCESS cycle.
      mem_we <= ls_gnt && ls_we;
      if (grant) begin
        mem_addr <= ls_gnt ? ls_addr : if_addr;
        if (ls_gnt) begin
          mem_wdata <= ls_wdata;
        end
        owner  <= ls_gnt;
        cancel <= if_gnt && if_flush;
      end

      if (state == ACCESS) begin
        if (owner && !mem_we) begin
          ls_rdata <= mem_rdata;
        end
        if (!owner) begin
          if_rdata <= mem_rdata;
        end
        if_valid <= !owner && !cancel && !if_flush;
        ls_valid <= owner;
      end else begin
        if_valid <= 1'b0;
        ls_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a read-only memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_valid;
  logic [15:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [15:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_valid;
  logic [15:0] ls_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks;
  int failures;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [15:0] mem_value(input logic [15:0] a);
    case (a)
      16'h0010: mem_value = 16'hA5A5;
      16'h0020: mem_value = 16'h2222;
      16'h0030: mem_value = 16'h3333;
      16'h0040: mem_value = 16'h4444;
      16'h0100: mem_value = 16'hBEEF;
      default:  mem_value = a ^ 16'hC3C3;
    endcase
  endfunction

  assign mem_rdata = mem_value(mem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [5:0] exp_ls_seq;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    if_req   = 1'b1;
    if_addr  = 16'h0010;
    if_flush = 1'b0;
    ls_req   = 1'b1;
    ls_we    = 1'b0;
    ls_addr  = 16'h0100;
    ls_wdata = 16'h0000;

    // Reset: grants held off, every output at its reset value
    @(negedge clk);
    #1;
    chk("rst_if_gnt", 16'(if_gnt), 16'h0);
    chk("rst_ls_gnt", 16'(ls_gnt), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_mem_we", 16'(mem_we), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_wdata", mem_wdata, 16'h0000);
    chk("rst_if_valid", 16'(if_valid), 16'h0);
    chk("rst_ls_valid", 16'(ls_valid), 16'h0);
    chk("rst_if_rdata", if_rdata, 16'h0000);
    chk("rst_ls_rdata", ls_rdata, 16'h0000);
    if_req = 1'b0;
    ls_req = 1'b0;
    reset  = 1'b0;
    next_cycle();

    // Single fetch
    if_req  = 1'b1;
    if_addr = 16'h0010;
    #1;
    chk("f1_if_gnt", 16'(if_gnt), 16'h1);
    chk("f1_ls_gnt", 16'(ls_gnt), 16'h0);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("f1_mem_addr", mem_addr, 16'h0010);
    chk("f1_busy", 16'(busy), 16'h1);
    chk("f1_mem_we", 16'(mem_we), 16'h0);
    chk("f1_valid_early", 16'(if_valid), 16'h0);
    next_cycle();
    #1;
    chk("f1_if_valid", 16'(if_valid), 16'h1);
    chk("f1_if_rdata", if_rdata, 16'hA5A5);
    next_cycle();
    #1;
    chk("f1_valid_drop", 16'(if_valid), 16'h0);
    chk("f1_busy_idle", 16'(busy), 16'h0);

    // Collision: load wins, fetch granted in the following RESP
    if_req  = 1'b1;
    if_addr = 16'h0020;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 16'h0100;
    #1;
    chk("c_ls_gnt0", 16'(ls_gnt), 16'h1);
    chk("c_if_gnt0", 16'(if_gnt), 16'h0);
    next_cycle();
    ls_req = 1'b0;
    #1;
    chk("c_mem_addr1", mem_addr, 16'h0100);
    chk("c_if_gnt1", 16'(if_gnt), 16'h0);
    next_cycle();
    #1;
    chk("c_ls_valid2", 16'(ls_valid), 16'h1);
    chk("c_ls_rdata2", ls_rdata, 16'hBEEF);
    chk("c_if_gnt2", 16'(if_gnt), 16'h1);
    chk("c_busy2", 16'(busy), 16'h1);
    next_cycle();
    if_req = 1'b0;
    #1;
    chk("c_mem_addr3", mem_addr, 16'h0020);
    chk("c_ls_valid3", 16'(ls_valid), 16'h0);
    next_cycle();
    #1;
    chk("c_if_valid4", 16'(if_valid), 16'h1);
    chk("c_if_rdata4", if_rdata, 16'h2222);
    next_cycle();

    // Starvation: both held; four loads, one fetch, then loads resume
    exp_ls_seq = 6'b101111;
    if_req  = 1'b1;
    if_addr = 16'h0010;
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 16'h0100;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("sv_ls_gnt%0d", i), 16'(ls_gnt), 16'(exp_ls_seq[i]));
      chk($sformatf("sv_if_gnt%0d", i), 16'(if_gnt), 16'(!exp_ls_seq[i]));
      next_cycle();
      #1;
      chk($sformatf("sv_access_gnt%0d", i), 16'(if_gnt | ls_gnt), 16'h0);
      next_cycle();
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    next_cycle();
    #1;
    chk("sv_idle", 16'(busy), 16'h0);

    // Store: one-cycle write strobe, ls_rdata untouched
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 16'h0200;
    ls_wdata = 16'h1234;
    #1;
    chk("st_ls_gnt", 16'(ls_gnt), 16'h1);
    chk("st_mem_we0", 16'(mem_we), 16'h0);
    next_cycle();
    ls_req = 1'b0;
    #1;
    chk("st_mem_we1", 16'(mem_we), 16'h1);
    chk("st_mem_addr1", mem_addr, 16'h0200);
    chk("st_mem_wdata1", mem_wdata, 16'h1234);
    next_cycle();
    #1;
    chk("st_mem_we2", 16'(mem_we), 16'h0);
    chk("st_ls_valid2", 16'(ls_valid), 16'h1);
    chk("st_ls_rdata2", ls_rdata, 16'hBEEF);
    chk("st_mem_addr_hold", mem_addr, 16'h0200);
    next_cycle();
    ls_we = 1'b0;

    // Flush during ACCESS suppresses the fetch response
    if_req  = 1'b1;
    if_addr = 16'h0030;
    #1;
    chk("fl_if_gnt", 16'(if_gnt), 16'h1);
    next_cycle();
    if_req   = 1'b0;
    if_flush = 1'b1;
    next_cycle();
    if_flush = 1'b0;
    #1;
    chk("fl_no_valid", 16'(if_valid), 16'h0);
    chk("fl_busy_resp", 16'(busy), 16'h1);
    next_cycle();
    #1;
    chk("fl_busy_idle", 16'(busy), 16'h0);

    // Flush in the grant cycle cancels the fetch
    if_req   = 1'b1;
    if_addr  = 16'h0010;
    if_flush = 1'b1;
    #1;
    chk("fg_if_gnt", 16'(if_gnt), 16'h1);
    next_cycle();
    if_req   = 1'b0;
    if_flush = 1'b0;
    next_cycle();
    #1;
    chk("fg_no_valid", 16'(if_valid), 16'h0);
    next_cycle();

    // Flush has no effect on a load
    ls_req   = 1'b1;
    ls_addr  = 16'h0055;
    if_flush = 1'b1;
    next_cycle();
    ls_req = 1'b0;
    next_cycle();
    #1;
    chk("fls_ls_valid", 16'(ls_valid), 16'h1);
    chk("fls_ls_rdata", ls_rdata, 16'h0055 ^ 16'hC3C3);
    next_cycle();

    // Flush in IDLE is ignored; the next fetch completes normally
    next_cycle();
    if_flush = 1'b0;
    if_req   = 1'b1;
    if_addr  = 16'h0040;
    next_cycle();
    if_req = 1'b0;
    next_cycle();
    #1;
    chk("fn_if_valid", 16'(if_valid), 16'h1);
    chk("fn_if_rdata", if_rdata, 16'h4444);
    next_cycle();

    // Reset during a store's ACCESS drops it
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 16'h0300;
    ls_wdata = 16'h7777;
    next_cycle();
    ls_req = 1'b0;
    ls_we  = 1'b0;
    reset  = 1'b1;
    #1;
    chk("rs_mem_we_access", 16'(mem_we), 16'h1);
    next_cycle();
    #1;
    chk("rs_mem_we", 16'(mem_we), 16'h0);
    chk("rs_ls_valid", 16'(ls_valid), 16'h0);
    chk("rs_busy", 16'(busy), 16'h0);
    chk("rs_mem_addr", mem_addr, 16'h0000);
    chk("rs_mem_wdata", mem_wdata, 16'h0000);
    chk("rs_ls_rdata", ls_rdata, 16'h0000);
    chk("rs_if_rdata", if_rdata, 16'h0000);
    reset = 1'b0;
    next_cycle();
    #1;
    chk("rs_after_ls_valid", 16'(ls_valid), 16'h0);
    chk("rs_after_mem_we", 16'(mem_we), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
